sort_job_scheduler: RTL and testbench

- Shares one `sorting` datapath between two requesters.
- Each requester submits a frame of up to N_ELEM bytes plus a sort direction. The scheduler grants one frame at a time by round-robin, stages the frame and bursts it into the sorter.
- It then captures the sorted result and returns it on a valid/ready output stream tagged with the requester id.
- It sits between the sorting block and its clients and owns the sorter's load_enable, data_in and sortType inputs.

---
 rtl/sort_job_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_sort_job_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_scheduler.sv
// sort_job_scheduler
//   Shares one sorting datapath between two requesters. A frame of up to
//   N_ELEM elements is granted round-robin, staged, burst into the sorter
//   (padded to N_ELEM so the pads sort to the tail), the sorted stream is
//   captured and then returned on a valid/ready stream tagged with the owner.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/ready/data/last/dir  requester N beat stream (dir: 0 asc, 1 desc)
//   srt_load_enable, srt_data_in    load port of the shared sorter
//   srt_sortType                    sort direction, held for the whole job
//   srt_data_out                    sorted stream from the sorter
//   out_valid/ready/data/last/id    result stream, tagged with requester id
//   busy                            high whenever a job is in flight
//   err_len                         pulse when a frame exceeds N_ELEM beats
module sort_job_scheduler #(
  parameter int N_ELEM   = 15,
  parameter int DATA_W   = 8,
  parameter int SORT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  input  logic              req0_dir,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  input  logic              req1_dir,
  output logic              srt_load_enable,
  output logic [DATA_W-1:0] srt_data_in,
  output logic              srt_sortType,
  input  logic [DATA_W-1:0] srt_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_id,
  output logic              busy,
  output logic              err_len
);

  localparam int CW = $clog2(N_ELEM + 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N_ELEM - 1);
  localparam logic [CW-1:0] FULL_LEN  = CW'(N_ELEM);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SORT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    DROP    = 3'd2,
    BURST   = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    SEND    = 3'd6
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              id;
  logic              dir;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     len;
  logic [DATA_W-1:0] stage_buf  [N_ELEM];
  logic [DATA_W-1:0] result_buf [N_ELEM];

  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic              rcv;
  logic              accept;

  // Beat stream of whichever requester currently owns the sorter.
  always_comb begin
    cur_valid = id ? req1_valid : req0_valid;
    cur_last  = id ? req1_last  : req0_last;
    cur_data  = id ? req1_data  : req0_data;
    rcv       = (state == RECV) || (state == DROP);
    accept    = rcv && cur_valid;
  end

  always_comb begin
    req0_ready      = rcv && !id;
    req1_ready      = rcv && id;
    err_len         = (state == RECV) && accept && !cur_last && (cnt == LAST_IDX);
    srt_load_enable = (state == BURST);
    srt_data_in     = '0;
    if (state == BURST) begin
      // Pads take the extreme value for the direction so they sort last.
      srt_data_in = (cnt < len) ? stage_buf[cnt] : {DATA_W{~dir}};
    end
    srt_sortType = dir && ((state == BURST) || (state == WAIT) || (state == CAPTURE));
    out_valid    = (state == SEND);
    out_data     = (state == SEND) ? result_buf[cnt] : '0;
    out_last     = (state == SEND) && (cnt == len - ONE);
    out_id       = (state == SEND) && id;
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      dir        <= 1'b0;
      cnt        <= '0;
      len        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0_valid && (!req1_valid || last_grant)) begin
            id         <= 1'b0;
            dir        <= req0_dir;
            last_grant <= 1'b0;
            state      <= RECV;
          end else if (req1_valid) begin
            id         <= 1'b1;
            dir        <= req1_dir;
            last_grant <= 1'b1;
            state      <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            if (cur_last) begin
              len   <= cnt + ONE;
              cnt   <= '0;
              state <= BURST;
            end else if (cnt == LAST_IDX) begin
              len   <= FULL_LEN;
              cnt   <= '0;
              state <= DROP;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        DROP: begin
          if (accept && cur_last) state <= BURST;
        end
        BURST: begin
          if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        CAPTURE: begin
          if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= SEND;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt == len - ONE) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data buffers need no reset: their contents are only read after being
  // written within the same job.
  always_ff @(posedge clk) begin
    if ((state == RECV) && accept) stage_buf[cnt] <= cur_data;
    if (state == CAPTURE) result_buf[cnt] <= srt_data_out;
  end

endmodule

// File: tb/tb_sort_job_scheduler.sv
module tb_sort_job_scheduler;

  localparam int N  = 15;
  localparam int SL = 2;

  typedef logic [7:0] vq_t[$];
  typedef struct { logic [7:0] data; logic last; logic dir; logic gap; } beat_t;
  typedef struct { logic [7:0] data; logic last; logic id; } exp_t;

  logic       clk, reset;
  logic       req0_valid, req0_ready, req0_last, req0_dir;
  logic       req1_valid, req1_ready, req1_last, req1_dir;
  logic [7:0] req0_data, req1_data;
  logic       srt_load_enable, srt_sortType;
  logic [7:0] srt_data_in, srt_data_out;
  logic       out_valid, out_ready, out_last, out_id, busy, err_len;
  logic [7:0] out_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_ov = 0;
  int   last_hs_cyc = 0;
  int   err_pulses = 0;
  int   nbeat0 = 0;
  int   err_beat0 = 0;
  logic bp_mode = 1'b0;

  beat_t bq0[$];
  beat_t bq1[$];
  exp_t  sb[$];

  sort_job_scheduler #(.N_ELEM(N), .DATA_W(8), .SORT_LAT(SL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_last(req0_last), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_last(req1_last), .req1_dir(req1_dir),
    .srt_load_enable(srt_load_enable), .srt_data_in(srt_data_in),
    .srt_sortType(srt_sortType), .srt_data_out(srt_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_id(out_id), .busy(busy), .err_len(err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural sorter: loads on load_enable, first sorted element appears
  // SL cycles after the first low cycle, one element per cycle.
  logic [7:0] mem [N];
  logic [7:0] srt [N];
  logic [7:0] next_out = 8'h5a;
  int lc = 0;
  int k = -1;
  int burst_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      lc = 0;
      k  = -1;
    end else if (srt_load_enable) begin
      if (lc < N) mem[lc] = srt_data_in;
      lc++;
      k = -1;
    end else if (lc > 0) begin
      burst_len = lc;
      if (lc == N) begin
        for (int i = 0; i < N; i++) srt[i] = mem[i];
        for (int i = 1; i < N; i++) begin
          for (int j = i; j > 0; j--) begin
            if (srt_sortType ? (srt[j] > srt[j-1]) : (srt[j] < srt[j-1])) begin
              logic [7:0] t;
              t = srt[j]; srt[j] = srt[j-1]; srt[j-1] = t;
            end
          end
        end
        k = 0;
      end
      lc = 0;
    end else if (k >= 0) begin
      k++;
    end
    next_out = (k >= 0 && k + 1 >= SL && k + 1 - SL < N) ? srt[k + 1 - SL] : 8'h5a;
  end

  always @(posedge clk) begin
    #1 srt_data_out = next_out;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = bp_mode ? !out_ready : 1'b1;
    end
  end

  task automatic set_req(input int r, input logic v, input beat_t b);
    if (r == 0) begin
      req0_valid = v; req0_data = b.data; req0_last = b.last; req0_dir = b.dir;
    end else begin
      req1_valid = v; req1_data = b.data; req1_last = b.last; req1_dir = b.dir;
    end
  endtask

  task automatic run_driver(input int r);
    beat_t b;
    beat_t idle_b;
    logic  ok;
    idle_b = '{8'h00, 1'b0, 1'b0, 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if ((r == 0 ? bq0.size() : bq1.size()) == 0) begin
        set_req(r, 1'b0, idle_b);
      end else begin
        b = (r == 0) ? bq0.pop_front() : bq1.pop_front();
        if (b.gap) begin
          set_req(r, 1'b0, idle_b);
          @(posedge clk);
          #1;
        end
        set_req(r, 1'b1, b);
        ok = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
          @(negedge clk);
          ok = (r == 0) ? req0_ready : req1_ready;
        end
        if (!ok) chk("ready_timeout", ok, 1);
        else if (r == 0) begin
          nbeat0++;
          if (err_len) err_beat0 = nbeat0;
          if (b.last) last_hs_cyc = cyc;
        end
      end
    end
  endtask

  initial run_driver(0);
  initial run_driver(1);

  // Output monitor / scoreboard.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (err_len) err_pulses++;
    if (reset) begin
      stall_prev = 1'b0;
    end else if (out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      if (stall_prev) chk("stall_stable", out_data, prev_data);
      if (out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          chk("out_id", out_id, e.id);
        end
      end
      stall_prev = !out_ready;
      prev_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send_beats(input int r, input vq_t v, input logic d, input logic gaps);
    beat_t b;
    foreach (v[i]) begin
      b = '{v[i], (i == v.size() - 1), d, gaps && ($urandom_range(0, 1) == 1)};
      if (r == 0) bq0.push_back(b);
      else bq1.push_back(b);
    end
  endtask

  task automatic expect_vals(input vq_t v, input logic rid);
    foreach (v[i]) sb.push_back('{v[i], (i == v.size() - 1), rid});
  endtask

  // Reference result: first N elements, bubble-sorted in the requested order.
  task automatic expect_sorted(input vq_t v, input logic d, input logic rid);
    vq_t a;
    logic [7:0] t;
    a = v;
    while (a.size() > N) void'(a.pop_back());
    for (int i = 0; i < a.size(); i++) begin
      for (int j = 0; j + 1 < a.size() - i; j++) begin
        if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    expect_vals(a, rid);
  endtask

  function automatic vq_t rand_frame(input int n);
    vq_t v;
    for (int i = 0; i < n; i++) v.push_back(8'($urandom_range(0, 255)));
    return v;
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 3000), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vq_t v, f0, f1;
    logic ok;
    int   d;
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0; req1_dir = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_load_enable", srt_load_enable, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_data_in", srt_data_in, 0);
    chk("rst_sortType", srt_sortType, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;

    // Full frame from req0, ascending
    first_ov = -1;
    v = '{121, 37, 11, 45, 246, 83, 180, 233, 96, 242, 104, 63, 3, 157, 28};
    expect_vals('{3, 11, 28, 37, 45, 63, 83, 96, 104, 121, 157, 180, 233, 242, 246}, 1'b0);
    send_beats(0, v, 1'b0, 1'b0);
    wait_drain("t1_drain");
    d = first_ov - last_hs_cyc;
    chk("t1_latency_window", (d >= 2 * N + SL) && (d <= 2 * N + SL + 3), 1);

    // Short descending frame from req1, padded with zeros
    expect_vals('{200, 17, 5}, 1'b1);
    send_beats(1, '{5, 200, 17}, 1'b1, 1'b0);
    wait_drain("t2_drain");
    chk("t2_burst_len", burst_len, N);
    ok = 1'b1;
    for (int i = 3; i < N; i++) if (mem[i] !== 8'h00) ok = 1'b0;
    chk("t2_pad_zero", ok, 1);

    // Simultaneous requests from reset: req0, then req1; a second tie goes to req0
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      f0 = rand_frame(6);
      f1 = rand_frame(9);
      expect_sorted(f0, 1'b0, 1'b0);
      expect_sorted(f1, 1'b1, 1'b1);
      send_beats(0, f0, 1'b0, 1'b0);
      send_beats(1, f1, 1'b1, 1'b0);
      wait_drain("tie_drain");
    end

    // Overflow: 17 beats, with gaps in valid
    nbeat0 = 0;
    err_beat0 = 0;
    d = err_pulses;
    v = rand_frame(17);
    expect_sorted(v, 1'b0, 1'b0);
    send_beats(0, v, 1'b0, 1'b1);
    wait_drain("ovf_drain");
    chk("ovf_err_pulses", err_pulses - d, 1);
    chk("ovf_err_beat", err_beat0, N);
    chk("ovf_beats_consumed", nbeat0, 17);

    // Backpressure during SEND
    bp_mode = 1'b1;
    v = rand_frame(N);
    expect_sorted(v, 1'b1, 1'b1);
    send_beats(1, v, 1'b1, 1'b0);
    wait_drain("bp_drain");
    bp_mode = 1'b0;

    // Reset during CAPTURE abandons the job
    send_beats(0, rand_frame(8), 1'b0, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = srt_load_enable;
    end
    chk("mid_burst_seen", ok, 1);
    for (int n = 0; n < 500 && ok; n++) begin
      @(negedge clk);
      ok = srt_load_enable;
    end
    chk("mid_burst_end", ok, 0);
    repeat (SL + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_load_enable", srt_load_enable, 0);
    reset = 1'b0;
    repeat (3 * N) @(negedge clk);
    chk("mid_rst_no_output_pending", sb.size(), 0);
    v = rand_frame(11);
    expect_sorted(v, 1'b1, 1'b0);
    send_beats(0, v, 1'b1, 1'b0);
    wait_drain("post_rst_drain");

    chk("total_err_pulses", err_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
